// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU control blocks.
// Contents:
//   REG_W    - register address width
//   ZERO_REG - index of the hard-wired zero register
//   state_t  - pipeline sequencer states (RUN, STALL, HALT, STEP)
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use hazard compare.
// Flags when the instruction in execute is a register-writing load whose
// destination is read by the instruction in fetch/decode.
// Ports:
//   fd_rs1, fd_rs2   in  source registers of the decode instruction
//   fd_uses_rs2      in  decode instruction actually reads rs2
//   ex_write_reg     in  destination register of the execute instruction
//   ex_reg_wrenable  in  execute instruction writes a register
//   ex_mem_to_reg    in  execute instruction is a load
//   hz               out load-use hazard present
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs2,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_wrenable,
  input  logic             ex_mem_to_reg,
  output logic             hz
);

  // Writes to the zero register are discarded, so they never create a hazard.
  assign hz = ex_reg_wrenable & ex_mem_to_reg & (ex_write_reg != ZERO_REG) &
              ((ex_write_reg == fd_rs1) | (fd_uses_rs2 & (ex_write_reg == fd_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer for the pipelined CPU.
// Drives the PC enable, the fetch/decode advance enable and bubble injection
// into execute. Resolves load-use hazards, squashes the wrong-path
// instruction after a taken jump and implements a debug halt/single-step
// handshake. Keeps saturating stall and flush event counters.
// Parameters:
//   LOAD_STALL  bubble cycles per load-use hazard (1..3)
//   CNT_W       width of the event counters
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   fd_rs1, fd_rs2, fd_uses_rs2   decode-stage source operands
//   ex_write_reg, ex_reg_wrenable,
//   ex_mem_to_reg, ex_is_jump     execute-stage instruction info
//   halt_req, step_req            debug halt level / single-step pulse
//   pc_en, fd_en, ex_bubble       combinational pipeline controls
//   halted                        registered, controller is in HALT
//   stall_cnt, flush_cnt          saturating event counters
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_STALL = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  input  logic             fd_uses_rs2,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_reg_wrenable,
  input  logic             ex_mem_to_reg,
  input  logic             ex_is_jump,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0]       STALL_INIT = 2'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t     state, state_next;
  logic [1:0] rem, rem_next;
  logic       ret_halt, ret_halt_next;
  logic       hz;
  logic       stall_inc, flush_inc;
  logic       pc_en_c, fd_en_c, ex_bubble_c;

  hazard_detect u_hazard_detect (
    .fd_rs1          (fd_rs1),
    .fd_rs2          (fd_rs2),
    .fd_uses_rs2     (fd_uses_rs2),
    .ex_write_reg    (ex_write_reg),
    .ex_reg_wrenable (ex_reg_wrenable),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .hz              (hz)
  );

  // STEP reuses the RUN decision for one instruction but ignores halt_req,
  // which is normally still high, and always returns to HALT afterwards.
  always_comb begin
    pc_en_c       = 1'b0;
    fd_en_c       = 1'b0;
    ex_bubble_c   = 1'b1;
    state_next    = state;
    rem_next      = rem;
    ret_halt_next = ret_halt;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state)
      RUN, STEP: begin
        if (ex_is_jump) begin
          pc_en_c    = 1'b1;
          fd_en_c    = 1'b1;
          flush_inc  = 1'b1;
          state_next = (state == STEP) ? HALT : RUN;
        end else if (hz) begin
          stall_inc = 1'b1;
          rem_next  = STALL_INIT;
          if (LOAD_STALL > 1) begin
            state_next    = STALL;
            ret_halt_next = (state == STEP);
          end else begin
            state_next = (state == STEP) ? HALT : RUN;
          end
        end else if (halt_req && (state == RUN)) begin
          state_next = HALT;
        end else begin
          pc_en_c     = 1'b1;
          fd_en_c     = 1'b1;
          ex_bubble_c = 1'b0;
          state_next  = (state == STEP) ? HALT : RUN;
        end
      end
      STALL: begin
        stall_inc = 1'b1;
        rem_next  = rem - 2'd1;
        // rem counts the bubbles still owed including this one.
        if (rem <= 2'd1) begin
          state_next    = ret_halt ? HALT : RUN;
          ret_halt_next = 1'b0;
        end
      end
      HALT: begin
        if (step_req) begin
          state_next = STEP;
        end else if (!halt_req) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Reset holds the pipeline frozen with bubbles regardless of state.
  assign pc_en     = rst_n & pc_en_c;
  assign fd_en     = rst_n & fd_en_c;
  assign ex_bubble = ~rst_n | ex_bubble_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      rem       <= 2'd0;
      ret_halt  <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      ret_halt <= ret_halt_next;
      halted   <= (state_next == HALT);
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (LOAD_STALL=2, CNT_W=4).
// Each test builds a table of per-cycle inputs with the expected
// {pc_en, fd_en, ex_bubble, halted}; expectations are queued into a
// scoreboard as stimulus is driven and popped when outputs are sampled.
module tb_pipeline_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] fd_rs1, fd_rs2, ex_write_reg;
  logic       fd_uses_rs2, ex_reg_wrenable, ex_mem_to_reg, ex_is_jump;
  logic       halt_req, step_req;
  logic       pc_en, fd_en, ex_bubble, halted;
  logic [3:0] stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use2;
    logic [4:0] wr;
    logic       wen;
    logic       m2r;
    logic       jmp;
    logic       hreq;
    logic       sreq;
    logic [3:0] exp;
  } vec_t;

  logic [3:0] sb[$];

  pipeline_ctrl #(.LOAD_STALL(2), .CNT_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fd_rs1          (fd_rs1),
    .fd_rs2          (fd_rs2),
    .fd_uses_rs2     (fd_uses_rs2),
    .ex_write_reg    (ex_write_reg),
    .ex_reg_wrenable (ex_reg_wrenable),
    .ex_mem_to_reg   (ex_mem_to_reg),
    .ex_is_jump      (ex_is_jump),
    .halt_req        (halt_req),
    .step_req        (step_req),
    .pc_en           (pc_en),
    .fd_en           (fd_en),
    .ex_bubble       (ex_bubble),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use2, input logic [4:0] wr,
                              input logic wen, input logic m2r, input logic jmp,
                              input logic hreq, input logic sreq,
                              input logic [3:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.wr = wr; v.wen = wen;
    v.m2r = m2r; v.jmp = jmp; v.hreq = hreq; v.sreq = sreq; v.exp = exp;
    return v;
  endfunction

  // Expected output patterns {pc_en, fd_en, ex_bubble, halted}
  localparam logic [3:0] E_RUN  = 4'b1100;
  localparam logic [3:0] E_BUB  = 4'b0010;
  localparam logic [3:0] E_JMP  = 4'b1110;
  localparam logic [3:0] E_HALT = 4'b0011;

  // Non-hazard instruction mix with optional halt/step requests.
  function automatic vec_t idle(input logic hreq, input logic sreq, input logic [3:0] exp);
    return mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, hreq, sreq, exp);
  endfunction

  // Load writing r5 while decode reads r5 through rs1.
  function automatic vec_t ld5(input logic hreq, input logic [3:0] exp);
    return mk(5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, hreq, 1'b0, exp);
  endfunction

  task automatic apply(input vec_t v);
    fd_rs1 = v.rs1; fd_rs2 = v.rs2; fd_uses_rs2 = v.use2;
    ex_write_reg = v.wr; ex_reg_wrenable = v.wen; ex_mem_to_reg = v.m2r;
    ex_is_jump = v.jmp; halt_req = v.hreq; step_req = v.sreq;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(idle(1'b0, 1'b0, E_RUN));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    apply(idle(1'b0, 1'b0, E_RUN));
    #1;
    got = {pc_en, fd_en, ex_bubble, halted};
    n_cmp++;
    if (got !== E_BUB) begin
      n_fail++;
      $display("[TB] FAIL reset_outs got=%b want=%b", got, E_BUB);
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_cnts got=%h want=00", {stall_cnt, flush_cnt});
    end
    do_reset();
  endtask

  task automatic test_load_use();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    q.push_back(ld5(1'b0, E_BUB));
    q.push_back(ld5(1'b0, E_BUB));
    q.push_back(mk(5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL load_use[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL load_use stall_cnt got=%0d want=2", stall_cnt);
    end
  endtask

  task automatic test_no_hazard();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    q.push_back(mk(5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN));
    q.push_back(mk(5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN));
    q.push_back(mk(5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN));
    q.push_back(mk(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN));
    q.push_back(mk(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_BUB));
    q.push_back(idle(1'b0, 1'b0, E_BUB));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL no_hazard[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL no_hazard stall_cnt got=%0d want=2", stall_cnt);
    end
  endtask

  task automatic test_jump_hazard();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    q.push_back(mk(5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_JMP));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    q.push_back(mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_JMP));
    q.push_back(idle(1'b1, 1'b0, E_BUB));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL jump_hazard[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {4'd0, 4'd2}) begin
      n_fail++;
      $display("[TB] FAIL jump_hazard cnts got=%0d/%0d want=0/2", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_halt_step();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    q.push_back(idle(1'b0, 1'b1, E_RUN));
    q.push_back(idle(1'b1, 1'b0, E_BUB));
    for (int k = 0; k < 10; k++) q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b1, 1'b1, E_HALT));
    q.push_back(idle(1'b1, 1'b0, E_RUN));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    q.push_back(idle(1'b0, 1'b1, E_RUN));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL halt_step[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step_hazard();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    q.push_back(idle(1'b1, 1'b0, E_BUB));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b1, 1'b1, E_HALT));
    q.push_back(ld5(1'b1, E_BUB));
    q.push_back(ld5(1'b1, E_BUB));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b1, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_HALT));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL step_hazard[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (stall_cnt !== 4'd2) begin
      n_fail++;
      $display("[TB] FAIL step_hazard stall_cnt got=%0d want=2", stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got;
    do_reset();
    // Enter STALL, then pull reset asynchronously.
    apply(ld5(1'b0, E_BUB));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    got = {pc_en, fd_en, ex_bubble, halted};
    n_cmp++;
    if (got !== E_BUB || stall_cnt !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_stall got=%b cnt=%0d want=%b cnt=0", got, stall_cnt, E_BUB);
    end
    apply(idle(1'b0, 1'b0, E_RUN));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    got = {pc_en, fd_en, ex_bubble, halted};
    n_cmp++;
    if (got !== E_RUN) begin
      n_fail++;
      $display("[TB] FAIL after_reset_stall got=%b want=%b", got, E_RUN);
    end
    // Enter HALT, then reset with halt_req released.
    @(posedge clk); #1;
    apply(idle(1'b1, 1'b0, E_BUB));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    apply(idle(1'b0, 1'b0, E_RUN));
    #1;
    got = {pc_en, fd_en, ex_bubble, halted};
    n_cmp++;
    if (got !== E_BUB) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_halt got=%b want=%b", got, E_BUB);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    got = {pc_en, fd_en, ex_bubble, halted};
    n_cmp++;
    if (got !== E_RUN) begin
      n_fail++;
      $display("[TB] FAIL after_reset_halt got=%b want=%b", got, E_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    vec_t q[$];
    logic [3:0] got, want;
    do_reset();
    for (int k = 0; k < 20; k++)
      q.push_back(mk(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_JMP));
    // Back-to-back load-use hazards: 8 x 2 stall cycles.
    for (int k = 0; k < 16; k++) q.push_back(ld5(1'b0, E_BUB));
    q.push_back(idle(1'b0, 1'b0, E_RUN));
    foreach (q[i]) begin
      apply(q[i]);
      sb.push_back(q[i].exp);
      @(negedge clk);
      got  = {pc_en, fd_en, ex_bubble, halted};
      want = sb.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d] outs got=%b want=%b", i, got, want);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (flush_cnt !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL sat flush_cnt got=%0d want=15", flush_cnt);
    end
    n_cmp++;
    if (stall_cnt !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL sat stall_cnt got=%0d want=15", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_jump_hazard();
    test_halt_step();
    test_step_hazard();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
